commit_cu: RTL and testbench
============================

Name: commit_cu

Overview:
Commit control unit. It sequences retirement of the ROB head instruction, using the commit type produced upstream by the commit-type decoder.
- Drives per-type commit side effects: integer RF write, store-buffer commit, CSR write, trap/mret signalling, pipeline flush.
- Serialises long operations (fence drain, WFI sleep, post-flush recovery).
- Sits between the ROB head and the architectural state and control path.

Parameters:
RECOVER_CYCLES, 2, cycles ready_o is held low after any flush (must be >=1)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  synchronous active-low reset
valid_i  in  1  ROB head valid and completed
ready_o  out  1  ROB head pop (handshake fires on valid_i & ready_o)
comm_type_i  in  expipe_pkg::comm_type_t  head commit type
mispredict_i  in  1  head branch/jump was mispredicted
sb_store_ready_i  in  1  store buffer accepts a commit
sb_empty_i  in  1  store buffer fully drained
irq_i  in  1  pending enabled interrupt (WFI wake)
int_rf_valid_o  out  1  integer RF write enable for head rd
sb_store_commit_o  out  1  mark head store committed
csr_valid_o  out  1  perform head CSR access
trap_o  out  1  take trap (exception/ecall/ebreak)
mret_o  out  1  execute mret
flush_o  out  1  flush front-end and back-end
fetch_stall_o  out  1  stall fetch (WFI sleep)
retired_o  out  1  instruction retired (minstret increment)

Behaviour:
- States (expipe_pkg::commit_cu_state_t): COMMIT, WAIT_FENCE, WAIT_WFI, RECOVER. Reset state is COMMIT, recovery counter = 0.
- All outputs are combinational from state and inputs. All are 0 while rst_n_i=0 and whenever valid_i=0 in COMMIT.
- Every side-effect output is asserted only in the same cycle the handshake fires. The one exception is sb_store_commit_o, which is held while waiting for store-buffer ready.
- COMMIT with valid_i=1, by comm_type_i:
  - INT_RF, LOAD: ready_o=1, int_rf_valid_o=1, retired_o=1.
  - STORE: sb_store_commit_o=1. ready_o=retired_o=sb_store_ready_i. Stay in COMMIT until accepted.
  - JUMP: ready_o=1, int_rf_valid_o=1, retired_o=1. If mispredict_i: flush_o=1, go to RECOVER.
  - BRANCH: ready_o=1, retired_o=1, no RF write. If mispredict_i: flush_o=1, go to RECOVER.
  - CSR: ready_o=1, csr_valid_o=1, int_rf_valid_o=1, retired_o=1, flush_o=1 (serialising), go to RECOVER.
  - EXCEPT, ECALL, EBREAK: ready_o=1, trap_o=1, flush_o=1, retired_o=0, go to RECOVER.
  - MRET: ready_o=1, mret_o=1, flush_o=1, retired_o=1, go to RECOVER.
  - WFI: ready_o=1, retired_o=1, go to WAIT_WFI.
  - FENCE: ready_o=0, go to WAIT_FENCE.
  - NONE: ready_o=1, retired_o=1, no side effects.
- WAIT_FENCE:
  - While sb_empty_i=0: ready_o=0.
  - When sb_empty_i=1: ready_o=1, retired_o=1, flush_o=1, go to RECOVER. The FENCE retires in that cycle.
- WAIT_WFI:
  - fetch_stall_o=1, ready_o=0.
  - When irq_i=1: go to COMMIT next cycle. fetch_stall_o drops in the COMMIT cycle.
  - irq_i already high on WFI commit: one WAIT_WFI cycle still occurs.
- RECOVER:
  - ready_o=0 and valid_i is ignored.
  - Counter loads RECOVER_CYCLES-1 on entry and decrements each cycle; at 0, go to COMMIT.
  - Counter width is $clog2(RECOVER_CYCLES+1). Total ready_o=0 time is exactly RECOVER_CYCLES cycles.
- Simultaneous events:
  - flush_o and retired_o may be asserted in the same cycle.
  - mispredict_i is ignored for non-branch/jump types.
  - irq_i is ignored outside WAIT_WFI; trap entry is handled by the exception path.
- Reset mid-operation (any state, any counter value): next cycle is COMMIT, counter 0, no pending store commit.
- At most one instruction commits per cycle.

Decomposition:
- Add commit_cu_state_t (4-value enum) to expipe_pkg next to comm_type_t.
- comm_type_t is reused unchanged.
- No sub-module: the recovery down-counter and the FSM are inline (~200 lines).

Test Plan:
- ADD head, valid_i=1 for 3 cycles -> ready_o=int_rf_valid_o=retired_o=1 each cycle; state stays COMMIT.
- STORE head, sb_store_ready_i low 2 cycles then high -> sb_store_commit_o=1 for 3 cycles, ready_o=1 only in cycle 3, retired_o pulses once.
- BRANCH with mispredict_i=1, RECOVER_CYCLES=2 -> flush_o=1 for 1 cycle, then ready_o=0 for exactly 2 cycles with valid_i held high, then ready_o=1.
- FENCE with sb_empty_i low 4 cycles -> ready_o=0 for 4 cycles; on sb_empty_i=1: ready_o=retired_o=flush_o=1, then RECOVER.
- WFI then irq_i asserted after 5 cycles -> fetch_stall_o=1 for those 5 cycles plus the irq cycle, then COMMIT. Separately, ECALL -> trap_o=flush_o=1, retired_o=0.
- rst_n_i=0 asserted mid-RECOVER and mid-WAIT_WFI -> next cycle all outputs 0, state COMMIT, a new ADD commits immediately after reset release.

Source files
------------

// File: rtl/expipe_pkg.sv
// Shared execution-pipe types: the commit type from the commit-type decoder
// and the state encoding of the commit control unit.
package expipe_pkg;

  // Commit category of the ROB head instruction
  typedef enum logic [3:0] {
    NONE,
    INT_RF,
    LOAD,
    STORE,
    JUMP,
    BRANCH,
    CSR,
    EXCEPT,
    ECALL,
    EBREAK,
    MRET,
    WFI,
    FENCE
  } comm_type_t;

  // Commit control unit sequencing states
  typedef enum logic [1:0] {
    COMMIT,
    WAIT_FENCE,
    WAIT_WFI,
    RECOVER
  } commit_cu_state_t;

  // Default number of cycles the head is blocked after a flush
  localparam int RECOVER_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/commit_cu.sv
// Commit control unit: retires the ROB head, drives the per-type architectural
// side effects and serialises fences, WFI sleep and post-flush recovery.
module commit_cu
  import expipe_pkg::*;
#(
  parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  comm_type_t comm_type_i,
  input  logic       mispredict_i,
  input  logic       sb_store_ready_i,
  input  logic       sb_empty_i,
  input  logic       irq_i,
  output logic       int_rf_valid_o,
  output logic       sb_store_commit_o,
  output logic       csr_valid_o,
  output logic       trap_o,
  output logic       mret_o,
  output logic       flush_o,
  output logic       fetch_stall_o,
  output logic       retired_o
);

  localparam int CNT_W = $clog2(RECOVER_CYCLES + 1);
  // The entry cycle into RECOVER counts as the first blocked cycle
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RECOVER_CYCLES - 1);

  commit_cu_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and recovery counter registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= COMMIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and side-effect outputs; everything forced low in reset
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    ready_o           = 1'b0;
    int_rf_valid_o    = 1'b0;
    sb_store_commit_o = 1'b0;
    csr_valid_o       = 1'b0;
    trap_o            = 1'b0;
    mret_o            = 1'b0;
    flush_o           = 1'b0;
    fetch_stall_o     = 1'b0;
    retired_o         = 1'b0;

    case (state_q)
      COMMIT: begin
        if (valid_i) begin
          case (comm_type_i)
            INT_RF, LOAD: begin
              ready_o        = 1'b1;
              int_rf_valid_o = 1'b1;
              retired_o      = 1'b1;
            end
            STORE: begin
              sb_store_commit_o = 1'b1;
              ready_o           = sb_store_ready_i;
              retired_o         = sb_store_ready_i;
            end
            JUMP, BRANCH: begin
              ready_o        = 1'b1;
              retired_o      = 1'b1;
              int_rf_valid_o = (comm_type_i == JUMP);
              if (mispredict_i) begin
                flush_o = 1'b1;
                state_d = RECOVER;
                cnt_d   = CNT_LOAD;
              end
            end
            CSR: begin
              ready_o        = 1'b1;
              csr_valid_o    = 1'b1;
              int_rf_valid_o = 1'b1;
              retired_o      = 1'b1;
              flush_o        = 1'b1;
              state_d        = RECOVER;
              cnt_d          = CNT_LOAD;
            end
            EXCEPT, ECALL, EBREAK: begin
              ready_o = 1'b1;
              trap_o  = 1'b1;
              flush_o = 1'b1;
              state_d = RECOVER;
              cnt_d   = CNT_LOAD;
            end
            MRET: begin
              ready_o   = 1'b1;
              mret_o    = 1'b1;
              flush_o   = 1'b1;
              retired_o = 1'b1;
              state_d   = RECOVER;
              cnt_d     = CNT_LOAD;
            end
            WFI: begin
              ready_o   = 1'b1;
              retired_o = 1'b1;
              state_d   = WAIT_WFI;
            end
            FENCE: begin
              state_d = WAIT_FENCE;
            end
            default: begin
              ready_o   = 1'b1;
              retired_o = 1'b1;
            end
          endcase
        end
      end
      WAIT_FENCE: begin
        if (sb_empty_i) begin
          ready_o   = 1'b1;
          retired_o = 1'b1;
          flush_o   = 1'b1;
          state_d   = RECOVER;
          cnt_d     = CNT_LOAD;
        end
      end
      WAIT_WFI: begin
        fetch_stall_o = 1'b1;
        if (irq_i) begin
          state_d = COMMIT;
        end
      end
      RECOVER: begin
        if (cnt_q == '0) begin
          state_d = COMMIT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = COMMIT;
        cnt_d   = '0;
      end
    endcase

    if (!rst_n_i) begin
      ready_o           = 1'b0;
      int_rf_valid_o    = 1'b0;
      sb_store_commit_o = 1'b0;
      csr_valid_o       = 1'b0;
      trap_o            = 1'b0;
      mret_o            = 1'b0;
      flush_o           = 1'b0;
      fetch_stall_o     = 1'b0;
      retired_o         = 1'b0;
    end
  end

endmodule

// File: tb/tb_commit_cu.sv
// Testbench for commit_cu: directed scenarios followed by random traffic, all
// checked cycle by cycle against a behavioural model of the commit rules.
module tb_commit_cu;
  import expipe_pkg::*;

  localparam int RC = 2;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       valid_i = 1'b0;
  comm_type_t comm_type_i = NONE;
  logic       mispredict_i = 1'b0;
  logic       sb_store_ready_i = 1'b0;
  logic       sb_empty_i = 1'b0;
  logic       irq_i = 1'b0;
  logic       ready_o, int_rf_valid_o, sb_store_commit_o, csr_valid_o;
  logic       trap_o, mret_o, flush_o, fetch_stall_o, retired_o;

  int checks = 0;
  int errors = 0;

  // Reference model: cycles still blocked after a flush, and sleep/fence flags
  int recLeft = 0;
  bit asleep  = 1'b0;
  bit fencing = 1'b0;

  commit_cu #(.RECOVER_CYCLES(RC)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
    .comm_type_i(comm_type_i), .mispredict_i(mispredict_i),
    .sb_store_ready_i(sb_store_ready_i), .sb_empty_i(sb_empty_i), .irq_i(irq_i),
    .int_rf_valid_o(int_rf_valid_o), .sb_store_commit_o(sb_store_commit_o),
    .csr_valid_o(csr_valid_o), .trap_o(trap_o), .mret_o(mret_o),
    .flush_o(flush_o), .fetch_stall_o(fetch_stall_o), .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected outputs packed as {ready,rf,sb,csr,trap,mret,flush,stall,retired}
  function automatic logic [8:0] modelOut();
    logic rdy, rf, sb, csr, trp, mrt, fl, stl, ret;
    {rdy, rf, sb, csr, trp, mrt, fl, stl, ret} = 9'b0;
    if (!rst_n_i || recLeft > 0) begin
      // blocked or in reset: nothing happens
    end else if (asleep) begin
      stl = 1'b1;
    end else if (fencing) begin
      if (sb_empty_i) {rdy, ret, fl} = 3'b111;
    end else if (valid_i) begin
      case (comm_type_i)
        INT_RF, LOAD:          {rdy, rf, ret} = 3'b111;
        STORE:                 begin sb = 1'b1; rdy = sb_store_ready_i; ret = sb_store_ready_i; end
        JUMP:                  begin {rdy, rf, ret} = 3'b111; fl = mispredict_i; end
        BRANCH:                begin {rdy, ret} = 2'b11; fl = mispredict_i; end
        CSR:                   {rdy, csr, rf, ret, fl} = 5'b11111;
        EXCEPT, ECALL, EBREAK: {rdy, trp, fl} = 3'b111;
        MRET:                  {rdy, mrt, fl, ret} = 4'b1111;
        WFI:                   {rdy, ret} = 2'b11;
        FENCE:                 rdy = 1'b0;
        default:               {rdy, ret} = 2'b11;
      endcase
    end
    return {rdy, rf, sb, csr, trp, mrt, fl, stl, ret};
  endfunction

  // Advance the model across one rising edge using the inputs of this cycle
  task automatic modelClock();
    logic [8:0] o;
    o = modelOut();
    if (!rst_n_i) begin
      recLeft = 0; asleep = 1'b0; fencing = 1'b0;
    end else if (recLeft > 0) begin
      recLeft--;
    end else if (asleep) begin
      if (irq_i) asleep = 1'b0;
    end else if (fencing) begin
      if (sb_empty_i) begin fencing = 1'b0; recLeft = RC; end
    end else if (valid_i) begin
      if (o[2]) recLeft = RC;
      else if (comm_type_i == WFI) asleep = 1'b1;
      else if (comm_type_i == FENCE) fencing = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic v, input comm_type_t t, input logic mis,
                               input logic sbr, input logic sbe, input logic irq,
                               input logic rstn);
    valid_i = v; comm_type_i = t; mispredict_i = mis;
    sb_store_ready_i = sbr; sb_empty_i = sbe; irq_i = irq; rst_n_i = rstn;
  endtask

  task automatic checkOutput(input string tag);
    logic [8:0] obs, exp;
    #1;
    exp = modelOut();
    obs = {ready_o, int_rf_valid_o, sb_store_commit_o, csr_valid_o, trap_o,
           mret_o, flush_o, fetch_stall_o, retired_o};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b (ready,rf,sb,csr,trap,mret,flush,stall,ret)",
             tag, obs, exp);
    end
  endtask

  // One full cycle: drive, check mid-cycle, clock the model, return to negedge
  task automatic step(input string tag, input logic v, input comm_type_t t,
                      input logic mis, input logic sbr, input logic sbe,
                      input logic irq, input logic rstn);
    applyStimulus(v, t, mis, sbr, sbe, irq, rstn);
    checkOutput(tag);
    @(posedge clk_i);
    modelClock();
    @(negedge clk_i);
  endtask

  initial begin
    @(negedge clk_i);
    repeat (2) step("reset", 1, INT_RF, 0, 1, 1, 1, 0);

    repeat (3) step("add", 1, INT_RF, 0, 0, 0, 0, 1);

    step("store_wait0", 1, STORE, 0, 0, 0, 0, 1);
    step("store_wait1", 1, STORE, 0, 0, 0, 0, 1);
    step("store_accept", 1, STORE, 0, 1, 0, 0, 1);

    step("branch_mispred", 1, BRANCH, 1, 0, 0, 0, 1);
    repeat (RC) step("branch_recover", 1, INT_RF, 1, 0, 0, 0, 1);
    step("after_recover", 1, INT_RF, 0, 0, 0, 0, 1);

    step("fence_enter", 1, FENCE, 0, 0, 0, 0, 1);
    repeat (4) step("fence_drain", 1, FENCE, 0, 0, 0, 0, 1);
    step("fence_retire", 1, FENCE, 0, 0, 1, 0, 1);
    repeat (RC) step("fence_recover", 1, INT_RF, 0, 0, 1, 0, 1);

    step("wfi_commit", 1, WFI, 0, 0, 0, 0, 1);
    repeat (5) step("wfi_sleep", 1, INT_RF, 0, 0, 0, 0, 1);
    step("wfi_irq", 1, INT_RF, 0, 0, 0, 1, 1);
    step("wfi_wake_add", 1, INT_RF, 0, 0, 0, 1, 1);

    step("wfi_irq_early", 1, WFI, 0, 0, 0, 1, 1);
    step("wfi_one_cycle", 1, INT_RF, 0, 0, 0, 1, 1);
    step("wfi_early_wake", 1, INT_RF, 0, 0, 0, 0, 1);

    step("ecall", 1, ECALL, 1, 0, 0, 1, 1);
    repeat (RC) step("ecall_recover", 1, INT_RF, 0, 0, 0, 0, 1);

    step("mret", 1, MRET, 0, 0, 0, 0, 1);
    step("mid_recover", 1, INT_RF, 0, 0, 0, 0, 1);
    step("rst_in_recover", 1, INT_RF, 0, 0, 0, 0, 0);
    step("add_after_rst1", 1, INT_RF, 0, 0, 0, 0, 1);

    step("wfi_again", 1, WFI, 0, 0, 0, 0, 1);
    step("mid_wfi", 1, INT_RF, 0, 0, 0, 0, 1);
    step("rst_in_wfi", 1, INT_RF, 0, 0, 0, 0, 0);
    step("add_after_rst2", 1, INT_RF, 0, 0, 0, 0, 1);

    step("idle", 0, CSR, 0, 1, 1, 1, 1);

    for (int i = 0; i < 3000; i++) begin
      step("random",
           ($urandom_range(0, 9) < 8),
           comm_type_t'($urandom_range(0, 12)),
           $urandom_range(0, 1),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 49) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
